// File: rtl/arm_prefetch_buffer.sv
// Instruction prefetch buffer: fetches ARM words over a single-outstanding req/ack bus
// into a small FIFO and hands them to decode; a taken branch flushes and redirects fetch.
module arm_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  // Request FSM; BUSY is exactly the registered bus request.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } req_state_e;

  req_state_e    state;
  logic [31:0]   mem_word [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   target_w;
  logic          discard;
  logic          ack_live;
  logic          push;
  logic          pop;
  logic          has_room;

  // Decode handshake: a word transfers on a cycle where inst_valid and inst_ready are both
  // high; the head and its PC stay stable until then. A branch in that cycle cancels it.
  assign inst_valid = (count != '0);
  assign inst_data  = mem_word[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign fetch_req  = (state == BUSY);

  assign target_w = branch_target & 32'hFFFF_FFFC;
  assign ack_live = fetch_req & fetch_ack;
  assign push     = ack_live & ~discard & ~branch;
  assign pop      = inst_valid & inst_ready & ~branch;

  always_comb begin
    count_next = count;
    if (branch)
      count_next = '0;
    else
      count_next = count + CW'(push) - CW'(pop);
  end

  assign has_room = (count_next < FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= '0;
      fetch_pc   <= RESET_PC_W;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      discard    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_word[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      count <= count_next;
      if (branch) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= target_w;
        // An unacked request must still complete on the bus; its data is dropped later.
        discard  <= fetch_req & ~fetch_ack;
        if (state == IDLE || fetch_ack) begin
          state      <= BUSY;
          fetch_addr <= target_w;
        end
      end else begin
        if (push) begin
          mem_word[wr_ptr] <= fetch_rdata;
          mem_pc[wr_ptr]   <= fetch_addr;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (state == IDLE) begin
          if (has_room) begin
            state      <= BUSY;
            fetch_addr <= fetch_pc;
          end
        end else if (fetch_ack) begin
          if (discard) begin
            // fetch_pc already holds the branch target; request it right away.
            discard <= 1'b0;
            if (has_room)
              fetch_addr <= fetch_pc;
            else
              state <= IDLE;
          end else begin
            fetch_pc <= fetch_pc + 32'd4;
            if (has_room)
              fetch_addr <= fetch_addr + 32'd4;
            else
              state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arm_prefetch_buffer.sv
// Directed bench for arm_prefetch_buffer: a bus responder, a scoreboard of expected
// {pc, word} pairs checked by a monitor on every decode transfer, and a wrap-around instance.
module tb_arm_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] branch_target;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        rst_w;
  logic        fetch_req_w;
  logic [31:0] fetch_addr_w;
  logic [31:0] fetch_rdata_w;
  logic        inst_valid_w;
  logic [31:0] inst_data_w;
  logic [31:0] inst_pc_w;
  logic        fetch_ack_w = 1'b1;
  logic        inst_ready_w = 1'b1;
  logic        branch_w = 1'b0;
  logic [31:0] branch_target_w = '0;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic        bus_stall;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] wrap_pcs [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  arm_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .branch_target (branch_target),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .fetch_rdata   (fetch_rdata),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  arm_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .rst           (rst_w),
    .branch        (branch_w),
    .branch_target (branch_target_w),
    .fetch_req     (fetch_req_w),
    .fetch_addr    (fetch_addr_w),
    .fetch_ack     (fetch_ack_w),
    .fetch_rdata   (fetch_rdata_w),
    .inst_valid    (inst_valid_w),
    .inst_data     (inst_data_w),
    .inst_pc       (inst_pc_w),
    .inst_ready    (inst_ready_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  always_comb fetch_rdata_w = mem_word(fetch_addr_w);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch = 1'b0;
    bus_stall = 1'b0;
    #1;
    chk("reset fetch_req", 32'(fetch_req), 32'd0);
    chk("reset fetch_addr", fetch_addr, 32'd0);
    chk("reset inst_valid", 32'(inst_valid), 32'd0);
    chk("reset inst_data", inst_data, 32'd0);
    chk("reset inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    for (int i = 0; i < 20; i++) begin
      if (fetch_req && fetch_addr == a) break;
      tick(1);
    end
    chk("reach fetch_addr", fetch_addr, a);
  endtask

  task automatic wait_empty(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- bus responder + bus rule checks ----------------
  always @(negedge clk) begin
    if (rst) begin
      fetch_ack = 1'b0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (prev_req && !prev_ack) begin
        chk("bus req held", 32'(fetch_req), 32'd1);
        chk("bus addr held", fetch_addr, prev_addr);
      end
      if (fetch_req) begin
        chk("bus addr aligned", 32'(fetch_addr[1:0]), 32'd0);
        fetch_ack   = !bus_stall;
        fetch_rdata = mem_word(fetch_addr);
      end else begin
        // Stray ack with junk data while idle must be ignored.
        fetch_ack   = 1'b1;
        fetch_rdata = 32'hDEAD_BEEF;
      end
      prev_req  = fetch_req;
      prev_ack  = fetch_ack;
      prev_addr = fetch_addr;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !branch) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: unexpected pc=%h data=%h, expected no transfer", inst_pc, inst_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({inst_pc, inst_data} !== exp_e)
          begin
            bad++;
            $display("FAIL scoreboard: got pc=%h data=%h expected pc=%h data=%h",
                     inst_pc, inst_data, exp_e[63:32], exp_e[31:0]);
          end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    rst_w = 1'b1;
    branch = 1'b0;
    branch_target = '0;
    inst_ready = 1'b0;
    bus_stall = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait streaming from reset.
    inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_push(32'(i * 4));
    do_reset();
    tick(1);
    chk("first req", 32'(fetch_req), 32'd1);
    chk("first addr", fetch_addr, 32'd0);
    tick(1);
    chk("latency valid", 32'(inst_valid), 32'd1);
    chk("latency pc", inst_pc, 32'd0);
    tick(16);
    chk("stream one per cycle", 32'(exp_q.size()), 32'd0);

    // Backpressure: fill, stall, drain.
    inst_ready = 1'b0;
    do_reset();
    tick(5);
    chk("full stops fetch", 32'(fetch_req), 32'd0);
    chk("full head valid", 32'(inst_valid), 32'd1);
    chk("full head pc", inst_pc, 32'd0);
    tick(3);
    chk("full stays idle", 32'(fetch_req), 32'd0);
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8); exp_push(32'hC);
    inst_ready = 1'b1;
    tick(1);
    chk("resume req", 32'(fetch_req), 32'd1);
    chk("resume addr", fetch_addr, 32'h10);
    bus_stall = 1'b1;
    wait_empty(10);

    // Branch while idle with a full queue and ready high.
    inst_ready = 1'b0;
    do_reset();
    tick(5);
    chk("idle before branch", 32'(fetch_req), 32'd0);
    branch = 1'b1;
    branch_target = 32'h103;
    inst_ready = 1'b1;
    tick(1);
    branch = 1'b0;
    chk("branch idle flush", 32'(inst_valid), 32'd0);
    chk("branch idle req", 32'(fetch_req), 32'd1);
    chk("branch idle addr", fetch_addr, 32'h100);
    exp_push(32'h100); exp_push(32'h104);
    tick(2);
    bus_stall = 1'b1;
    wait_empty(10);
    chk("branch idle next addr", fetch_addr, 32'h108);

    // Branch with a request in flight.
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_push(32'(i * 4));
    do_reset();
    wait_addr(32'h20);
    bus_stall = 1'b1;
    tick(1);
    branch = 1'b1;
    branch_target = 32'h400;
    tick(1);
    branch = 1'b0;
    chk("discard req held", 32'(fetch_req), 32'd1);
    chk("discard addr held", fetch_addr, 32'h20);
    chk("discard flush", 32'(inst_valid), 32'd0);
    tick(1);
    bus_stall = 1'b0;
    tick(1);
    chk("after discard req", 32'(fetch_req), 32'd1);
    chk("after discard addr", fetch_addr, 32'h400);
    chk("discarded data dropped", 32'(inst_valid), 32'd0);
    exp_push(32'h400); exp_push(32'h404);
    tick(2);
    bus_stall = 1'b1;
    wait_empty(10);

    // Branch coincident with an ack and a ready head.
    inst_ready = 1'b1;
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    do_reset();
    wait_addr(32'h10);
    branch = 1'b1;
    branch_target = 32'h80;
    tick(1);
    branch = 1'b0;
    chk("coincident flush", 32'(inst_valid), 32'd0);
    chk("coincident req", 32'(fetch_req), 32'd1);
    chk("coincident addr", fetch_addr, 32'h80);
    exp_push(32'h80); exp_push(32'h84);
    tick(2);
    bus_stall = 1'b1;
    wait_empty(10);

    // Address wrap from a high reset PC, then reset mid-request.
    rst_w = 1'b0;
    tick(1);
    chk("wrap first addr", fetch_addr_w, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("wrap valid", 32'(inst_valid_w), 32'd1);
      chk("wrap pc", inst_pc_w, wrap_pcs[i]);
      chk("wrap data", inst_data_w, mem_word(wrap_pcs[i]));
    end
    chk("wrap req in flight", 32'(fetch_req_w), 32'd1);
    rst_w = 1'b1;
    #1;
    chk("async reset fetch_req", 32'(fetch_req_w), 32'd0);
    chk("async reset fetch_addr", fetch_addr_w, 32'd0);
    chk("async reset inst_valid", 32'(inst_valid_w), 32'd0);
    chk("async reset inst_data", inst_data_w, 32'd0);
    chk("async reset inst_pc", inst_pc_w, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
